// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory for the memory stage: one request at a time,
// byte/half/word load-store formatting, fault detection and optional wait states.
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0,
    parameter int INIT_ZERO   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;
    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0 : 32'hxxxxxxxx;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    logic [31:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic                  valid_q, valid_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word, load_data, wd_lanes;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [3:0]       be;
    logic             fault, access, mem_we;

    always_comb begin
        lane    = addr_q[1:0];
        idx     = addr_q[IDX_W+1:2];
        rd_word = mem[idx];
        fault   = (size_q == 2'b11) || (size_q == 2'b01 && addr_q[0])
               || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
               || ({1'b0, addr_q} >= ADDR_LIMIT);
        b = rd_word[8*lane +: 8];
        h = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   load_data = uns_q ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_data = rd_word;
        endcase
        // Store data is replicated across lanes so the byte enables alone pick the target.
        case (size_q)
            2'b00: begin
                be       = 4'b0001 << lane;
                wd_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wd_lanes = wdata_q;
            end
        endcase
        access = (state_q == BUSY) && (cnt_q == 4'd0);
        mem_we = access && write_q && !fault && !reset;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                size_d  = req_size;
                uns_d   = req_unsigned;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                cnt_d   = 4'(WAIT_STATES);
                state_d = BUSY;
            end
            BUSY: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                rdata_d = (fault || write_q) ? 32'h0 : load_data;
                fault_d = fault;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: if (resp_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            valid_q <= valid_d;
        end
    end

    // RAM contents survive reset; a store is dropped if reset is high at its access edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
            end
        end
    end

    assign req_ready  = (state_q == IDLE) && !reset;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: a zero-wait instance for formatting and
// faults, and a three-wait instance for backpressure and mid-operation reset.
module tb_data_memory_lsu;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst0, req_valid0, req_ready0, req_write0, req_uns0;
    logic [1:0]  req_size0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic        resp_valid0, resp_ready0, resp_fault0;

    logic        rst3, req_valid3, req_ready3, req_write3, req_uns3;
    logic [1:0]  req_size3;
    logic [31:0] req_addr3, req_wdata3, resp_rdata3;
    logic        resp_valid3, resp_ready3, resp_fault3;

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32), .WAIT_STATES(0), .INIT_ZERO(1)) dut0 (
        .clk(clk), .reset(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_size(req_size0), .req_unsigned(req_uns0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .resp_valid(resp_valid0),
        .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_fault(resp_fault0)
    );

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32), .WAIT_STATES(3), .INIT_ZERO(1)) dut3 (
        .clk(clk), .reset(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write3), .req_size(req_size3), .req_unsigned(req_uns3),
        .req_addr(req_addr3), .req_wdata(req_wdata3), .resp_valid(resp_valid3),
        .resp_ready(resp_ready3), .resp_rdata(resp_rdata3), .resp_fault(resp_fault3)
    );

    // One transaction on dut0 with resp_ready high; lat counts edges from acceptance
    // to the first cycle resp_valid is seen (99 = never seen).
    task automatic acc0(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output logic rdy);
        @(negedge clk);
        rdy = req_ready0;
        req_valid0 = 1'b1; req_write0 = w; req_size0 = sz; req_uns0 = u;
        req_addr0 = a; req_wdata0 = wd; resp_ready0 = 1'b1;
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        lat = 99; rd = 32'h0; flt = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid0) begin
                lat = k; rd = resp_rdata0; flt = resp_fault0;
                break;
            end
        end
    endtask

    task automatic acc3(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat);
        @(negedge clk);
        req_valid3 = 1'b1; req_write3 = w; req_size3 = sz; req_uns3 = u;
        req_addr3 = a; req_wdata3 = wd; resp_ready3 = 1'b1;
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        lat = 99; rd = 32'h0; flt = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid3) begin
                lat = k; rd = resp_rdata3; flt = resp_fault3;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (req_ready0 !== 1'b0 || resp_valid0 !== 1'b0 || resp_rdata0 !== 32'h0 || resp_fault0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b rd=%h flt=%b want 0 0 0 0",
                     req_ready0, resp_valid0, resp_rdata0, resp_fault0);
        end
        rst0 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready0 !== 1'b1 || resp_valid0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b vld=%b want 1 0", req_ready0, resp_valid0);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic flt, rdy; int lat;
        acc0(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'h0 || flt !== 1'b0 || lat != 1 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL store_word got rd=%h flt=%b lat=%0d rdy=%b want 0 0 1 1", rd, flt, lat, rdy);
        end
        acc0(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'hDEADBEEF || flt !== 1'b0 || lat != 1) begin
            bad++;
            $display("FAIL load_word got rd=%h flt=%b lat=%0d want deadbeef 0 1", rd, flt, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic flt, rdy; int lat;
        acc0(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, lat, rdy);
        @(negedge clk);
        total++;
        if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
            bad++;
            $display("FAIL one_cycle_resp got vld=%b rdy=%b want 0 1", resp_valid0, req_ready0);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic flt, rdy; int lat;
        acc0(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF7F, rd, flt, lat, rdy);
        acc0(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'h0000007F || flt !== 1'b0) begin
            bad++;
            $display("FAIL byte_load_11 got rd=%h flt=%b want 0000007f 0", rd, flt);
        end
        acc0(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'hFFFFFFDE) begin
            bad++;
            $display("FAIL byte_load_13 got rd=%h want ffffffde", rd);
        end
        acc0(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'h000000DE) begin
            bad++;
            $display("FAIL ubyte_load_13 got rd=%h want 000000de", rd);
        end
        acc0(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'hDEAD7FEF) begin
            bad++;
            $display("FAIL word_after_byte got rd=%h want dead7fef", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic flt, rdy; int lat;
        acc0(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'h0000DEAD || flt !== 1'b0) begin
            bad++;
            $display("FAIL uhalf_load_12 got rd=%h flt=%b want 0000dead 0", rd, flt);
        end
        acc0(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'hFFFFDEAD) begin
            bad++;
            $display("FAIL shalf_load_12 got rd=%h want ffffdead", rd);
        end
        acc0(1'b1, 2'b01, 1'b0, 32'h14, 32'hABCD8001, rd, flt, lat, rdy);
        acc0(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'h00000080) begin
            bad++;
            $display("FAIL half_store_lane1 got rd=%h want 00000080", rd);
        end
        acc0(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'h00008001) begin
            bad++;
            $display("FAIL half_store_word got rd=%h want 00008001", rd);
        end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic flt, rdy; int lat;
        acc0(1'b1, 2'b01, 1'b0, 32'h13, 32'h00001234, rd, flt, lat, rdy);
        total++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            bad++;
            $display("FAIL half_store_misaligned got flt=%b rd=%h lat=%0d want 1 0 1", flt, rd, lat);
        end
        acc0(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, rd, flt, lat, rdy);
        total++;
        if (flt !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL word_load_misaligned got flt=%b rd=%h want 1 0", flt, rd);
        end
        acc0(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, flt, lat, rdy);
        total++;
        if (flt !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL size11_load got flt=%b rd=%h want 1 0", flt, rd);
        end
        acc0(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, rd, flt, lat, rdy);
        acc0(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'hDEAD7FEF || flt !== 1'b0) begin
            bad++;
            $display("FAIL word_after_faults got rd=%h flt=%b want dead7fef 0", rd, flt);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic flt, rdy; int lat;
        acc0(1'b0, 2'b10, 1'b0, DEPTH*4, 32'h0, rd, flt, lat, rdy);
        total++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            bad++;
            $display("FAIL oor_load got flt=%b rd=%h lat=%0d want 1 0 1", flt, rd, lat);
        end
        acc0(1'b1, 2'b10, 1'b0, DEPTH*4 + 32'h10, 32'h55555555, rd, flt, lat, rdy);
        total++;
        if (flt !== 1'b1) begin
            bad++;
            $display("FAIL oor_store got flt=%b want 1", flt);
        end
        acc0(1'b0, 2'b10, 1'b0, DEPTH*4 - 4, 32'h0, rd, flt, lat, rdy);
        total++;
        if (flt !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL last_word got flt=%b rd=%h want 0 0", flt, rd);
        end
        acc0(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, lat, rdy);
        total++;
        if (rd !== 32'hDEAD7FEF) begin
            bad++;
            $display("FAIL word_after_oor got rd=%h want dead7fef", rd);
        end
    endtask

    task automatic test_wait_backpressure();
        logic [31:0] rd; logic flt; int lat; int vlat; logic rdy_seen;
        acc3(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, rd, flt, lat);
        total++;
        if (lat != 4 || flt !== 1'b0) begin
            bad++;
            $display("FAIL w3_store_latency got lat=%0d flt=%b want 4 0", lat, flt);
        end
        @(negedge clk);
        req_valid3 = 1'b1; req_write3 = 1'b0; req_size3 = 2'b10; req_uns3 = 1'b0;
        req_addr3 = 32'h40; req_wdata3 = 32'h0; resp_ready3 = 1'b0;
        @(posedge clk);
        // Changes after acceptance must be ignored.
        #1 req_write3 = 1'b1; req_addr3 = 32'h44; req_wdata3 = 32'hFFFFFFFF;
        vlat = 99; rdy_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (req_ready3) rdy_seen = 1'b1;
            if (resp_valid3) begin
                vlat = k;
                break;
            end
        end
        total++;
        if (vlat != 4 || rdy_seen !== 1'b0 || resp_rdata3 !== 32'h12345678) begin
            bad++;
            $display("FAIL w3_load_latency got lat=%0d rdy=%b rd=%h want 4 0 12345678",
                     vlat, rdy_seen, resp_rdata3);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (resp_valid3 !== 1'b1 || resp_rdata3 !== 32'h12345678 || req_ready3 !== 1'b0) begin
                bad++;
                $display("FAIL w3_hold cycle=%0d got vld=%b rd=%h rdy=%b want 1 12345678 0",
                         k, resp_valid3, resp_rdata3, req_ready3);
            end
        end
        resp_ready3 = 1'b1;
        req_valid3 = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin
            bad++;
            $display("FAIL w3_release got vld=%b rdy=%b want 0 1", resp_valid3, req_ready3);
        end
        acc3(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL w3_late_change got rd=%h want 0", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic flt; int lat;
        acc3(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA5555, rd, flt, lat);
        @(negedge clk);
        req_valid3 = 1'b1; req_write3 = 1'b1; req_size3 = 2'b10; req_uns3 = 1'b0;
        req_addr3 = 32'h20; req_wdata3 = 32'hFFFFFFFF; resp_ready3 = 1'b1;
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        total++;
        if (req_ready3 !== 1'b0 || resp_valid3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async got rdy=%b vld=%b want 0 0", req_ready3, resp_valid3);
        end
        repeat (3) @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready3 !== 1'b1 || resp_valid3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after got rdy=%b vld=%b want 1 0", req_ready3, resp_valid3);
        end
        acc3(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'hAAAA5555 || lat != 4) begin
            bad++;
            $display("FAIL reset_mid_dropped got rd=%h lat=%0d want aaaa5555 4", rd, lat);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_size0 = 2'b00; req_uns0 = 1'b0;
        req_addr0 = 32'h0; req_wdata0 = 32'h0; resp_ready0 = 1'b1;
        req_valid3 = 1'b0; req_write3 = 1'b0; req_size3 = 2'b00; req_uns3 = 1'b0;
        req_addr3 = 32'h0; req_wdata3 = 32'h0; resp_ready3 = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_word();
        test_back_to_back();
        test_byte();
        test_half();
        test_fault();
        test_range();
        test_wait_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
